// File: rtl/clock_pkg.sv
// Shared definitions for the calendar clock blocks.
// Field-select encodings, per-field range limits, the reset date and the
// small arithmetic helpers used by the setting controller and the counter.
package clock_pkg;

  localparam logic [2:0] FLD_NONE = 3'd0;
  localparam logic [2:0] FLD_YEAR = 3'd1;
  localparam logic [2:0] FLD_MON  = 3'd2;
  localparam logic [2:0] FLD_DAY  = 3'd3;
  localparam logic [2:0] FLD_HOUR = 3'd4;
  localparam logic [2:0] FLD_MIN  = 3'd5;
  localparam logic [2:0] FLD_SEC  = 3'd6;

  localparam logic [6:0] SEC_MAX  = 7'd59;
  localparam logic [6:0] MIN_MAX  = 7'd59;
  localparam logic [6:0] HOUR_MAX = 7'd23;
  localparam logic [6:0] MON_MAX  = 7'd12;

  localparam logic [13:0] RST_YEAR = 14'd2024;
  localparam logic [6:0]  RST_MON  = 7'd1;
  localparam logic [6:0]  RST_DAY  = 7'd1;
  localparam logic [6:0]  RST_HOUR = 7'd0;
  localparam logic [6:0]  RST_MIN  = 7'd0;
  localparam logic [6:0]  RST_SEC  = 7'd0;

  // Gregorian leap-year rule.
  function automatic logic is_leap(input logic [13:0] year);
    logic div4, div100, div400;
    div4   = ((year % 14'd4)   == 14'd0);
    div100 = ((year % 14'd100) == 14'd0);
    div400 = ((year % 14'd400) == 14'd0);
    return (div4 && !div100) || div400;
  endfunction

  // One step up or down inside [lo, hi], wrapping at either end.
  // Values already outside the range land on the opposite limit.
  function automatic logic [13:0] wrap_step(input logic [13:0] val,
                                            input logic [13:0] lo,
                                            input logic [13:0] hi,
                                            input logic        up);
    logic [13:0] res;
    if (up) res = (val >= hi) ? lo : val + 14'd1;
    else    res = (val <= lo) ? hi : val - 14'd1;
    return res;
  endfunction

endpackage

// File: rtl/clock_set_ctrl_if.sv
// Bundle between the time-setting controller and its neighbours.
//   tick_1hz, btn_*   : one-cycle pulses from divider / debouncer
//   cur_*             : running date/time from the calendar counter
//   run_en, load      : counter advance enable and load strobe
//   set_*             : edit registers, also the counter load value
//   field_sel         : field under edit, for display blinking
// slave  = the controller, master = the surrounding logic.
interface clock_set_ctrl_if;

  logic        tick_1hz;
  logic        btn_mode;
  logic        btn_next;
  logic        btn_inc;
  logic        btn_dec;
  logic [13:0] cur_year;
  logic [6:0]  cur_mon;
  logic [6:0]  cur_day;
  logic [6:0]  cur_hour;
  logic [6:0]  cur_min;
  logic [6:0]  cur_sec;
  logic        run_en;
  logic        load;
  logic [13:0] set_year;
  logic [6:0]  set_mon;
  logic [6:0]  set_day;
  logic [6:0]  set_hour;
  logic [6:0]  set_min;
  logic [6:0]  set_sec;
  logic [2:0]  field_sel;

  modport slave (
    input  tick_1hz, btn_mode, btn_next, btn_inc, btn_dec,
    input  cur_year, cur_mon, cur_day, cur_hour, cur_min, cur_sec,
    output run_en, load, field_sel,
    output set_year, set_mon, set_day, set_hour, set_min, set_sec
  );

  modport master (
    output tick_1hz, btn_mode, btn_next, btn_inc, btn_dec,
    output cur_year, cur_mon, cur_day, cur_hour, cur_min, cur_sec,
    input  run_en, load, field_sel,
    input  set_year, set_mon, set_day, set_hour, set_min, set_sec
  );

endinterface

// File: rtl/month_days.sv
// Number of days in a month, leap-aware.
//   mon     : month 1..12 (anything else reports 31)
//   year    : full year, used only for February
//   max_day : 28..31
// Purely combinational; also used by the calendar counter.
module month_days
  import clock_pkg::*;
(
  input  logic [6:0]  mon,
  input  logic [13:0] year,
  output logic [6:0]  max_day
);

  always_comb begin
    max_day = 7'd31;
    case (mon)
      7'd4, 7'd6, 7'd9, 7'd11: max_day = 7'd30;
      7'd2:                    max_day = is_leap(year) ? 7'd29 : 7'd28;
      default:                 max_day = 7'd31;
    endcase
  end

endmodule

// File: rtl/clock_set_ctrl.sv
// Button-driven date/time setting controller.
// Snapshots the running calendar value, lets the user edit one field at a
// time (year, month, day, hour, minute, second) and loads the result back
// with a one-cycle strobe; the counter is held paused while editing.
//   clk, rst_n : system clock, async active-low reset
//   bus        : clock_set_ctrl_if.slave (buttons, tick, cur_*, set_*,
//                run_en, load, field_sel); all outputs registered.
//
// state  | meaning
// RUN    | counter free-running, waiting for btn_mode
// EDIT   | counter paused, field_sel selects the field being stepped
// COMMIT | one-cycle load of set_* into the counter
module clock_set_ctrl
  import clock_pkg::*;
#(
  parameter int YEAR_MIN  = 2000,
  parameter int YEAR_MAX  = 2099,
  parameter int TIMEOUT_S = 30
) (
  input  logic             clk,
  input  logic             rst_n,
  clock_set_ctrl_if.slave  bus
);

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_EDIT   = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;

  localparam logic [13:0] YMIN = 14'(YEAR_MIN);
  localparam logic [13:0] YMAX = 14'(YEAR_MAX);

  localparam int TMO_W = (TIMEOUT_S < 2) ? 1 : $clog2(TIMEOUT_S);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_S - 1);

  logic [1:0]       state_q, state_d;
  logic [2:0]       field_sel_q, field_sel_d;
  logic             run_en_q, run_en_d;
  logic             load_q, load_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [13:0]      set_year_q, set_year_d;
  logic [6:0]       set_mon_q, set_mon_d;
  logic [6:0]       set_day_q, set_day_d;
  logic [6:0]       set_hour_q, set_hour_d;
  logic [6:0]       set_min_q, set_min_d;
  logic [6:0]       set_sec_q, set_sec_d;

  logic        btn_any;
  logic        step_act;
  logic        step_up;
  logic        tmo_hit;
  logic [13:0] md_year;
  logic [6:0]  md_mon;
  logic [6:0]  md_max;

  assign btn_any  = bus.btn_mode | bus.btn_next | bus.btn_inc | bus.btn_dec;
  // inc/dec only act when no higher-priority button is present.
  assign step_act = (bus.btn_inc | bus.btn_dec) & ~bus.btn_mode & ~bus.btn_next;
  assign step_up  = bus.btn_inc;
  // Button in the same cycle as the tick wins, so no timeout then.
  assign tmo_hit  = bus.tick_1hz & ~btn_any & (tmo_q == TMO_LAST);

  // Month/year the edit registers will hold after this cycle. One shared
  // month_days lookup on these gives the bound for snapshot day clamp,
  // day-after-month/year-step clamp and day wrap alike.
  always_comb begin
    md_year = set_year_q;
    md_mon  = set_mon_q;
    if (state_q == ST_RUN) begin
      if (bus.cur_year < YMIN)      md_year = YMIN;
      else if (bus.cur_year > YMAX) md_year = YMAX;
      else                          md_year = bus.cur_year;
      if (bus.cur_mon == 7'd0)        md_mon = 7'd1;
      else if (bus.cur_mon > MON_MAX) md_mon = MON_MAX;
      else                            md_mon = bus.cur_mon;
    end else if (state_q == ST_EDIT && step_act) begin
      if (field_sel_q == FLD_YEAR)
        md_year = wrap_step(set_year_q, YMIN, YMAX, step_up);
      if (field_sel_q == FLD_MON)
        md_mon = 7'(wrap_step({7'd0, set_mon_q}, 14'd1, {7'd0, MON_MAX}, step_up));
    end
  end

  month_days u_month_days (
    .mon     (md_mon),
    .year    (md_year),
    .max_day (md_max)
  );

  always_comb begin
    state_d     = state_q;
    field_sel_d = field_sel_q;
    run_en_d    = run_en_q;
    load_d      = 1'b0;
    tmo_d       = tmo_q;
    set_year_d  = set_year_q;
    set_mon_d   = set_mon_q;
    set_day_d   = set_day_q;
    set_hour_d  = set_hour_q;
    set_min_d   = set_min_q;
    set_sec_d   = set_sec_q;

    case (state_q)
      ST_RUN: begin
        run_en_d    = 1'b1;
        field_sel_d = FLD_NONE;
        if (bus.btn_mode) begin
          set_year_d  = md_year;
          set_mon_d   = md_mon;
          if (bus.cur_day == 7'd0)     set_day_d = 7'd1;
          else if (bus.cur_day > md_max) set_day_d = md_max;
          else                         set_day_d = bus.cur_day;
          set_hour_d  = (bus.cur_hour > HOUR_MAX) ? HOUR_MAX : bus.cur_hour;
          set_min_d   = (bus.cur_min > MIN_MAX) ? MIN_MAX : bus.cur_min;
          set_sec_d   = (bus.cur_sec > SEC_MAX) ? SEC_MAX : bus.cur_sec;
          field_sel_d = FLD_YEAR;
          run_en_d    = 1'b0;
          tmo_d       = '0;
          state_d     = ST_EDIT;
        end
      end

      ST_EDIT: begin
        if (btn_any)           tmo_d = '0;
        else if (bus.tick_1hz) tmo_d = tmo_hit ? '0 : tmo_q + TMO_W'(1);

        if (bus.btn_mode || tmo_hit) begin
          field_sel_d = FLD_NONE;
          run_en_d    = 1'b1;
          state_d     = ST_RUN;
        end else if (bus.btn_next) begin
          if (field_sel_q == FLD_SEC) begin
            field_sel_d = FLD_NONE;
            load_d      = 1'b1;
            state_d     = ST_COMMIT;
          end else begin
            field_sel_d = field_sel_q + 3'd1;
          end
        end else if (step_act) begin
          case (field_sel_q)
            FLD_YEAR, FLD_MON: begin
              set_year_d = md_year;
              set_mon_d  = md_mon;
              if (set_day_q > md_max) set_day_d = md_max;
            end
            FLD_DAY:
              set_day_d = 7'(wrap_step({7'd0, set_day_q}, 14'd1, {7'd0, md_max}, step_up));
            FLD_HOUR:
              set_hour_d = 7'(wrap_step({7'd0, set_hour_q}, 14'd0, {7'd0, HOUR_MAX}, step_up));
            FLD_MIN:
              set_min_d = 7'(wrap_step({7'd0, set_min_q}, 14'd0, {7'd0, MIN_MAX}, step_up));
            FLD_SEC:
              set_sec_d = 7'(wrap_step({7'd0, set_sec_q}, 14'd0, {7'd0, SEC_MAX}, step_up));
            default: ;
          endcase
        end
      end

      ST_COMMIT: begin
        field_sel_d = FLD_NONE;
        run_en_d    = 1'b1;
        state_d     = ST_RUN;
      end

      default: begin
        field_sel_d = FLD_NONE;
        run_en_d    = 1'b1;
        state_d     = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      field_sel_q <= FLD_NONE;
      run_en_q    <= 1'b1;
      load_q      <= 1'b0;
      tmo_q       <= '0;
      set_year_q  <= RST_YEAR;
      set_mon_q   <= RST_MON;
      set_day_q   <= RST_DAY;
      set_hour_q  <= RST_HOUR;
      set_min_q   <= RST_MIN;
      set_sec_q   <= RST_SEC;
    end else begin
      state_q     <= state_d;
      field_sel_q <= field_sel_d;
      run_en_q    <= run_en_d;
      load_q      <= load_d;
      tmo_q       <= tmo_d;
      set_year_q  <= set_year_d;
      set_mon_q   <= set_mon_d;
      set_day_q   <= set_day_d;
      set_hour_q  <= set_hour_d;
      set_min_q   <= set_min_d;
      set_sec_q   <= set_sec_d;
    end
  end

  assign bus.run_en    = run_en_q;
  assign bus.load      = load_q;
  assign bus.field_sel = field_sel_q;
  assign bus.set_year  = set_year_q;
  assign bus.set_mon   = set_mon_q;
  assign bus.set_day   = set_day_q;
  assign bus.set_hour  = set_hour_q;
  assign bus.set_min   = set_min_q;
  assign bus.set_sec   = set_sec_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed testbench for clock_set_ctrl: inputs change on the falling edge,
// outputs are sampled on the falling edge after the active rising edge.
module tb_clock_set_ctrl;

  logic clk;
  logic rst_n;
  int   checks;
  int   passed;
  int   load_seen;

  clock_set_ctrl_if bus ();

  clock_set_ctrl #(.YEAR_MIN(2000), .YEAR_MAX(2099), .TIMEOUT_S(30)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (bus.load === 1'b1) load_seen++;

  task automatic set_cur(input int y, input int mo, input int d,
                         input int h, input int mi, input int s);
    bus.cur_year = 14'(y);
    bus.cur_mon  = 7'(mo);
    bus.cur_day  = 7'(d);
    bus.cur_hour = 7'(h);
    bus.cur_min  = 7'(mi);
    bus.cur_sec  = 7'(s);
  endtask

  // One-cycle pulse on the chosen inputs; returns at the sampling edge.
  task automatic press(input logic m, input logic n, input logic i,
                       input logic d, input logic t);
    @(negedge clk);
    bus.btn_mode = m; bus.btn_next = n; bus.btn_inc = i;
    bus.btn_dec = d;  bus.tick_1hz = t;
    @(negedge clk);
    bus.btn_mode = 0; bus.btn_next = 0; bus.btn_inc = 0;
    bus.btn_dec = 0;  bus.tick_1hz = 0;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) press(0, 0, 0, 0, 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({bus.run_en, bus.load, bus.field_sel} !== {1'b1, 1'b0, 3'd0})
      $display("FAIL reset_ctl run/load/fsel=%b/%b/%0d want 1/0/0", bus.run_en, bus.load, bus.field_sel);
    else passed++;
    checks++;
    if ({bus.set_year, bus.set_mon, bus.set_day, bus.set_hour, bus.set_min, bus.set_sec} !==
        {14'd2024, 7'd1, 7'd1, 7'd0, 7'd0, 7'd0})
      $display("FAIL reset_set got %0d-%0d-%0d %0d:%0d:%0d want 2024-1-1 0:0:0", bus.set_year,
               bus.set_mon, bus.set_day, bus.set_hour, bus.set_min, bus.set_sec);
    else passed++;
  endtask

  task automatic test_basic_set();
    int ls;
    set_cur(2024, 3, 15, 10, 20, 30);
    press(1, 0, 0, 0, 0);
    checks++;
    if ({bus.run_en, bus.field_sel, bus.set_year, bus.set_day} !== {1'b0, 3'd1, 14'd2024, 7'd15})
      $display("FAIL enter_edit run/fsel/year/day=%b/%0d/%0d/%0d want 0/1/2024/15",
               bus.run_en, bus.field_sel, bus.set_year, bus.set_day);
    else passed++;
    press(0, 0, 1, 0, 0);
    press(0, 0, 1, 0, 0);
    checks++;
    if (bus.set_year !== 14'd2026) $display("FAIL year_inc got %0d want 2026", bus.set_year);
    else passed++;
    for (int k = 0; k < 5; k++) press(0, 1, 0, 0, 0);
    checks++;
    if ({bus.field_sel, bus.run_en, bus.load} !== {3'd6, 1'b0, 1'b0})
      $display("FAIL at_sec fsel/run/load=%0d/%b/%b want 6/0/0", bus.field_sel, bus.run_en, bus.load);
    else passed++;
    ls = load_seen;
    press(0, 1, 0, 0, 0);
    checks++;
    if ({bus.load, bus.run_en, bus.field_sel} !== {1'b1, 1'b0, 3'd0})
      $display("FAIL commit load/run/fsel=%b/%b/%0d want 1/0/0", bus.load, bus.run_en, bus.field_sel);
    else passed++;
    checks++;
    if ({bus.set_year, bus.set_mon, bus.set_day, bus.set_hour, bus.set_min, bus.set_sec} !==
        {14'd2026, 7'd3, 7'd15, 7'd10, 7'd20, 7'd30})
      $display("FAIL load_val got %0d-%0d-%0d %0d:%0d:%0d want 2026-3-15 10:20:30", bus.set_year,
               bus.set_mon, bus.set_day, bus.set_hour, bus.set_min, bus.set_sec);
    else passed++;
    @(negedge clk);
    checks++;
    if ({bus.load, bus.run_en, load_seen} !== {1'b0, 1'b1, ls + 1})
      $display("FAIL after_commit load/run/pulses=%b/%b/%0d want 0/1/%0d", bus.load, bus.run_en,
               load_seen - ls, 1);
    else passed++;
  endtask

  task automatic test_day_clamp();
    set_cur(2024, 1, 31, 0, 0, 0);
    press(1, 0, 0, 0, 0);
    press(0, 1, 0, 0, 0);
    press(0, 0, 1, 0, 0);
    checks++;
    if ({bus.set_mon, bus.set_day} !== {7'd2, 7'd29})
      $display("FAIL clamp_leap mon/day=%0d/%0d want 2/29", bus.set_mon, bus.set_day);
    else passed++;
    press(1, 0, 0, 0, 0);
    set_cur(2023, 1, 31, 0, 0, 0);
    press(1, 0, 0, 0, 0);
    press(0, 1, 0, 0, 0);
    press(0, 0, 1, 0, 0);
    checks++;
    if ({bus.set_mon, bus.set_day} !== {7'd2, 7'd28})
      $display("FAIL clamp_noleap mon/day=%0d/%0d want 2/28", bus.set_mon, bus.set_day);
    else passed++;
    // Year step from 2024-02-29 to 2025 must pull the day back to 28.
    press(0, 0, 0, 1, 0);
    press(1, 0, 0, 0, 0);
    set_cur(2024, 2, 29, 0, 0, 0);
    press(1, 0, 0, 0, 0);
    press(0, 0, 1, 0, 0);
    checks++;
    if ({bus.set_year, bus.set_day} !== {14'd2025, 7'd28})
      $display("FAIL clamp_year year/day=%0d/%0d want 2025/28", bus.set_year, bus.set_day);
    else passed++;
    press(1, 0, 0, 0, 0);
  endtask

  task automatic test_wrap();
    set_cur(2099, 4, 1, 23, 0, 0);
    press(1, 0, 0, 0, 0);
    press(0, 0, 1, 0, 0);
    checks++;
    if (bus.set_year !== 14'd2000) $display("FAIL wrap_year got %0d want 2000", bus.set_year);
    else passed++;
    press(0, 1, 0, 0, 0);
    press(0, 1, 0, 0, 0);
    press(0, 0, 0, 1, 0);
    checks++;
    if (bus.set_day !== 7'd30) $display("FAIL wrap_day got %0d want 30", bus.set_day);
    else passed++;
    press(0, 1, 0, 0, 0);
    press(0, 0, 1, 0, 0);
    checks++;
    if (bus.set_hour !== 7'd0) $display("FAIL wrap_hour got %0d want 0", bus.set_hour);
    else passed++;
    press(0, 1, 0, 0, 0);
    press(0, 0, 0, 1, 0);
    checks++;
    if (bus.set_min !== 7'd59) $display("FAIL wrap_min got %0d want 59", bus.set_min);
    else passed++;
    press(0, 1, 0, 0, 0);
    press(0, 0, 0, 1, 0);
    checks++;
    if ({bus.field_sel, bus.set_sec} !== {3'd6, 7'd59})
      $display("FAIL wrap_sec fsel/sec=%0d/%0d want 6/59", bus.field_sel, bus.set_sec);
    else passed++;
    press(1, 0, 0, 0, 0);
  endtask

  task automatic test_snapshot_clamp();
    set_cur(1990, 13, 40, 25, 61, 70);
    press(1, 0, 0, 0, 0);
    checks++;
    if ({bus.set_year, bus.set_mon, bus.set_day, bus.set_hour, bus.set_min, bus.set_sec} !==
        {14'd2000, 7'd12, 7'd31, 7'd23, 7'd59, 7'd59})
      $display("FAIL snap_hi got %0d-%0d-%0d %0d:%0d:%0d want 2000-12-31 23:59:59", bus.set_year,
               bus.set_mon, bus.set_day, bus.set_hour, bus.set_min, bus.set_sec);
    else passed++;
    press(1, 0, 0, 0, 0);
    set_cur(3000, 0, 0, 5, 6, 7);
    press(1, 0, 0, 0, 0);
    checks++;
    if ({bus.set_year, bus.set_mon, bus.set_day} !== {14'd2099, 7'd1, 7'd1})
      $display("FAIL snap_lo got %0d-%0d-%0d want 2099-1-1", bus.set_year, bus.set_mon, bus.set_day);
    else passed++;
    press(1, 0, 0, 0, 0);
  endtask

  task automatic test_abort();
    int ls;
    ls = load_seen;
    set_cur(2030, 6, 10, 1, 2, 3);
    press(1, 0, 0, 0, 0);
    press(0, 0, 1, 0, 0);
    press(0, 1, 0, 0, 0);
    press(1, 0, 0, 0, 0);
    checks++;
    if ({bus.run_en, bus.field_sel} !== {1'b1, 3'd0})
      $display("FAIL abort_mode run/fsel=%b/%0d want 1/0", bus.run_en, bus.field_sel);
    else passed++;
    press(1, 0, 0, 0, 0);
    ticks(29);
    checks++;
    if ({bus.run_en, bus.field_sel} !== {1'b0, 3'd1})
      $display("FAIL tmo_29 run/fsel=%b/%0d want 0/1", bus.run_en, bus.field_sel);
    else passed++;
    ticks(1);
    checks++;
    if ({bus.run_en, bus.field_sel} !== {1'b1, 3'd0})
      $display("FAIL tmo_30 run/fsel=%b/%0d want 1/0", bus.run_en, bus.field_sel);
    else passed++;
    // 29 ticks, then a tick together with a button: button wins and clears.
    press(1, 0, 0, 0, 0);
    ticks(29);
    press(0, 0, 1, 0, 1);
    ticks(29);
    checks++;
    if ({bus.run_en, bus.field_sel} !== {1'b0, 3'd1})
      $display("FAIL tmo_cleared run/fsel=%b/%0d want 0/1", bus.run_en, bus.field_sel);
    else passed++;
    ticks(1);
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.run_en, bus.field_sel, load_seen} !== {1'b1, 3'd0, ls})
      $display("FAIL tmo_again run/fsel/loads=%b/%0d/%0d want 1/0/0", bus.run_en, bus.field_sel,
               load_seen - ls);
    else passed++;
  endtask

  task automatic test_priority();
    set_cur(2050, 7, 7, 7, 7, 7);
    press(1, 0, 0, 0, 0);
    press(0, 1, 1, 0, 0);
    checks++;
    if ({bus.field_sel, bus.set_year, bus.set_mon} !== {3'd2, 14'd2050, 7'd7})
      $display("FAIL prio_next fsel/year/mon=%0d/%0d/%0d want 2/2050/7", bus.field_sel,
               bus.set_year, bus.set_mon);
    else passed++;
    press(1, 1, 0, 0, 0);
    checks++;
    if ({bus.run_en, bus.field_sel, bus.load} !== {1'b1, 3'd0, 1'b0})
      $display("FAIL prio_mode run/fsel/load=%b/%0d/%b want 1/0/0", bus.run_en, bus.field_sel, bus.load);
    else passed++;
  endtask

  task automatic test_back_to_back();
    set_cur(2040, 8, 8, 8, 8, 8);
    press(1, 0, 0, 0, 0);
    for (int k = 0; k < 6; k++) press(0, 1, 0, 0, 0);
    // Mode pressed during the load cycle is dropped.
    bus.btn_mode = 1;
    @(negedge clk);
    bus.btn_mode = 0;
    checks++;
    if ({bus.load, bus.run_en, bus.field_sel} !== {1'b0, 1'b1, 3'd0})
      $display("FAIL commit_drop load/run/fsel=%b/%b/%0d want 0/1/0", bus.load, bus.run_en, bus.field_sel);
    else passed++;
    press(1, 0, 0, 0, 0);
    checks++;
    if ({bus.run_en, bus.field_sel, bus.set_year} !== {1'b0, 3'd1, 14'd2040})
      $display("FAIL reenter run/fsel/year=%b/%0d/%0d want 0/1/2040", bus.run_en, bus.field_sel, bus.set_year);
    else passed++;
    press(1, 0, 0, 0, 0);
  endtask

  task automatic test_reset_mid();
    set_cur(2060, 9, 9, 9, 9, 9);
    press(1, 0, 0, 0, 0);
    for (int k = 0; k < 6; k++) press(0, 1, 0, 0, 0);
    checks++;
    if (bus.load !== 1'b1) $display("FAIL pre_reset_load got %b want 1", bus.load);
    else passed++;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.load, bus.run_en, bus.field_sel, bus.set_year, bus.set_mon, bus.set_day} !==
        {1'b0, 1'b1, 3'd0, 14'd2024, 7'd1, 7'd1})
      $display("FAIL async_reset load/run/fsel/y/m/d=%b/%b/%0d/%0d/%0d/%0d want 0/1/0/2024/1/1",
               bus.load, bus.run_en, bus.field_sel, bus.set_year, bus.set_mon, bus.set_day);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    press(1, 0, 0, 0, 0);
    checks++;
    if ({bus.run_en, bus.field_sel, bus.set_year} !== {1'b0, 3'd1, 14'd2060})
      $display("FAIL post_reset_run run/fsel/year=%b/%0d/%0d want 0/1/2060", bus.run_en,
               bus.field_sel, bus.set_year);
    else passed++;
  endtask

  initial begin
    checks = 0; passed = 0; load_seen = 0;
    rst_n = 1'b0;
    bus.tick_1hz = 0; bus.btn_mode = 0; bus.btn_next = 0;
    bus.btn_inc = 0;  bus.btn_dec = 0;
    set_cur(2024, 1, 1, 0, 0, 0);
    test_reset();
    test_basic_set();
    test_day_clamp();
    test_wrap();
    test_snapshot_clamp();
    test_abort();
    test_priority();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/clock_set_ctrl.md
# clock_set_ctrl

Button-driven time-setting controller for the perpetual calendar counter. It snapshots the running date/time, lets the user edit one field at a time (year → month → day → hour → minute → second), then loads the edited value back into the counter with a one-cycle load strobe. While editing, it holds the counter paused. It sits between the debounced push-button logic and the calendar counter, and feeds the field selection to the display driver for blinking.

## Interface
Parameters:
- `YEAR_MIN`, default 2000: lowest settable year.
- `YEAR_MAX`, default 2099: highest settable year.
- `TIMEOUT_S`, default 30: number of `tick_1hz` pulses with no button press before the edit is aborted.

Ports:
- `clk`  in  1: system clock; all state changes on the rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `tick_1hz`  in  1: one-`clk` pulse per second from the clock divider.
- `btn_mode`, `btn_next`, `btn_inc`, `btn_dec`  in  1 each: debounced single-cycle button pulses.
- `cur_year`  in  14: current count from the calendar counter.
- `cur_mon`, `cur_day`, `cur_hour`, `cur_min`, `cur_sec`  in  7 each: current count from the calendar counter.
- `run_en`  out  1: counter advance enable; low while editing.
- `load`  out  1: one-cycle strobe; the counter takes the `set_*` values.
- `set_year`  out  14: edit register, also the load value.
- `set_mon`, `set_day`, `set_hour`, `set_min`, `set_sec`  out  7 each: edit registers, also the load values.
- `field_sel`  out  3: field being edited. 0 = none, 1 = year, 2 = month, 3 = day, 4 = hour, 5 = minute, 6 = second.

## Operation
States: `RUN`, `EDIT`, `COMMIT`.

- **Reset:**
  - State `RUN`; `run_en` = 1; `load` = 0; `field_sel` = 0.
  - `set_*` = 2024-01-01 00:00:00.
  - Timeout counter = 0.
- **RUN:**
  - `btn_mode` copies `cur_*` into `set_*`, sets `field_sel` = 1 and moves to `EDIT`.
  - All other buttons are ignored.
- **EDIT** (one button acted on per cycle, priority mode > next > inc > dec):
  - `btn_mode` aborts: go to `RUN`, `field_sel` = 0, no `load`.
  - `btn_next` with `field_sel` < 6: `field_sel` + 1.
  - `btn_next` with `field_sel` = 6: go to `COMMIT`.
  - `btn_inc` / `btn_dec` step the selected field by ±1, wrapping within its range:
    - second and minute: 0..59.
    - hour: 0..23.
    - day: 1..maxDay.
    - month: 1..12.
    - year: `YEAR_MIN`..`YEAR_MAX`.
  - Any button press clears the timeout counter.
  - `tick_1hz` increments the timeout counter. Reaching `TIMEOUT_S` aborts exactly as `btn_mode` does.
- **COMMIT:**
  - `load` = 1 for exactly this one cycle; `field_sel` = 0.
  - Next state is `RUN`.
- **maxDay:**
  - 31 for months 1, 3, 5, 7, 8, 10, 12; 30 for months 4, 6, 9, 11.
  - February: 29 if the year is a leap year (divisible by 4 and not by 100, or divisible by 400), else 28.
- **Day clamp:** when a month or year step makes `set_day` > new maxDay, `set_day` becomes the new maxDay in the same cycle as that step.
- **Snapshot clamp:** `cur_*` outside the legal ranges is saturated to the nearest limit on capture, including year to `YEAR_MIN`..`YEAR_MAX`.
- Button inputs arriving in `COMMIT` are dropped.

## Timing
- All outputs are registered.
- **Entering edit:** `btn_mode` in cycle N (in `RUN`) gives `run_en` = 0, `field_sel` = 1 and `set_*` = snapshot in cycle N+1.
- **Field edits:** an edit button in cycle N is visible on `set_*` / `field_sel` in cycle N+1.
- **Commit:** final `btn_next` in cycle N gives `load` = 1 in cycle N+1. In cycle N+2, `load` = 0 and `run_en` = 1.
- **Paused interval:** `run_en` stays low from the cycle after the snapshot through the `load` cycle inclusive. The counter cannot tick between snapshot and load.
- **Abort:** in the cycle after the abort, `run_en` = 1 and `load` never asserts.
- **Simultaneous `tick_1hz` and a button:** the button wins, and the timeout counter is cleared rather than incremented.
- **`rst_n` low at any time:** immediately forces the reset values, including mid-`COMMIT`; `load` drops asynchronously.

## Structure
- **Shared package `clock_pkg`:**
  - Field-select encodings (`FLD_NONE`..`FLD_SEC`).
  - Range limits: 59, 23, 12.
  - Reset date constants (2024-01-01 00:00:00).
  - Leap-year function `is_leap`.
- **Sub-module `month_days`:** combinational month (7 bits) + year (14 bits) → maxDay (7 bits). The calendar counter reuses it.

## Test plan
- **Basic set:** reset; `cur_*` = 2024-03-15 10:20:30; `btn_mode`; `btn_inc` ×2 on year; `btn_next` ×6 → `load` for one cycle with 2026-03-15 10:20:30; `run_en` high the next cycle.
- **Day clamp:** snapshot 2024-01-31; `btn_next` (to month), `btn_inc` → `set_mon` = 2 and `set_day` = 29. Repeat from 2023-01-31 → `set_day` = 28.
- **Wrap-around:**
  - `btn_dec` on second 0 → 59.
  - `btn_inc` on hour 23 → 0.
  - `btn_inc` on year 2099 → 2000.
  - `btn_dec` on day 1 in April → 30.
- **Abort:** `btn_mode` in `EDIT` after edits → no `load`; `run_en` = 1 next cycle; `field_sel` = 0. With no buttons, 30 `tick_1hz` pulses → same abort; 29 pulses plus one button → no abort.
- **Priority:** `btn_next` and `btn_inc` together on the year field → only `field_sel` advances, year unchanged. `btn_mode` + `btn_next` → abort.
- **Reset mid-operation:** assert `rst_n` low while `load` = 1 → `load` drops immediately; all outputs at reset values; after release, state is `RUN`.
